// File: rtl/switch_vga_hex.sv
// Board-top VGA renderer: shows NUM_DIGITS hex digits from `value` as seven-segment glyphs.
// Owns its pixel-clock divider, raster counters, frame-synchronous value latch and a 2-stage pixel pipeline.
module switch_vga_hex #(
  parameter int          NUM_DIGITS = 4,
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          X0         = 64,
  parameter int          Y0         = 176,
  parameter logic [23:0] FG_COLOR   = 24'h00FF00,
  parameter logic [23:0] BG_COLOR   = 24'h000020,
  parameter bit          LZ_BLANK   = 1'b1
) (
  input  logic                    clk_fpga,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B,
  output logic                    VGA_CLK,
  output logic                    VGA_SYNC_N,
  output logic                    VGA_BLANK_N,
  output logic                    VGA_HS,
  output logic                    VGA_VS,
  output logic                    frame_start
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW         = $clog2(H_TOTAL);
  localparam int VW         = $clog2(V_TOTAL);
  localparam int VAL_W      = 4 * NUM_DIGITS;
  localparam int CELL_PITCH = 80;
  localparam int CELL_W     = 64;
  localparam int CELL_H     = 128;

  // Segment mask per hex digit, ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  // Which segment rectangles contain a cell-local pixel, same {a..g} order.
  function automatic logic [6:0] seg_area(input logic [5:0] x, input logic [6:0] y);
    logic xl, xm, xr, yt, yu, ym, yl, yb;
    xl = (x < 6'd8);
    xm = (x >= 6'd8) && (x < 6'd56);
    xr = (x >= 6'd56);
    yt = (y < 7'd8);
    yu = (y >= 7'd8) && (y < 7'd60);
    ym = (y >= 7'd60) && (y < 7'd68);
    yl = (y >= 7'd68) && (y < 7'd120);
    yb = (y >= 7'd120);
    return {xm && yt, xr && yu, xr && yl, xm && yb, xl && yl, xl && yu, xm && ym};
  endfunction

  logic             div;
  logic             pix_tick;
  logic [HW-1:0]    h;
  logic [VW-1:0]    v;
  logic             h_wrap;
  logic             v_wrap;
  logic             latch_now;
  logic [VAL_W-1:0] latched;

  assign pix_tick  = div;
  assign h_wrap    = (h == HW'(H_TOTAL - 1));
  assign v_wrap    = (v == VW'(V_TOTAL - 1));
  assign latch_now = pix_tick && h_wrap && (v == VW'(V_ACTIVE - 1));

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) div <= 1'b0;
    else       div <= ~div;
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (pix_tick) begin
      if (h_wrap) begin
        h <= '0;
        v <= v_wrap ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Sampling only on entry to the first blanking line keeps every visible frame tear-free.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      latched     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= latch_now;
      if (latch_now) latched <= value;
    end
  end

  // ---- stage 0: combinational decode of the raster position ----
  logic                  vld_p0, hs_p0, vs_p0;
  logic                  in_cell_p0, blank_lz_p0;
  logic [3:0]            nib_p0;
  logic [HW-1:0]         hx, ci, cxw;
  logic [VW-1:0]         vy;
  logic                  h_ge_x0, v_ge_y0;
  logic [NUM_DIGITS-1:0] lz_run;
  logic                  lz_acc;

  assign vld_p0 = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
  assign hs_p0  = !((int'(h) >= H_ACTIVE + H_FP) && (int'(h) < H_ACTIVE + H_FP + H_SYNC));
  assign vs_p0  = !((int'(v) >= V_ACTIVE + V_FP) && (int'(v) < V_ACTIVE + V_FP + V_SYNC));

  // lz_run[d]: every nibble from the leftmost digit through digit d is zero.
  always_comb begin
    lz_run = '0;
    lz_acc = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      lz_acc    = lz_acc && (latched[4*(NUM_DIGITS-1-d) +: 4] == 4'h0);
      lz_run[d] = lz_acc;
    end
  end

  always_comb begin
    h_ge_x0     = (int'(h) >= X0);
    v_ge_y0     = (int'(v) >= Y0);
    hx          = h - HW'(X0);
    vy          = v - VW'(Y0);
    ci          = hx / HW'(CELL_PITCH);
    cxw         = hx % HW'(CELL_PITCH);
    in_cell_p0  = h_ge_x0 && v_ge_y0 && (int'(ci) < NUM_DIGITS) &&
                  (int'(cxw) < CELL_W) && (int'(vy) < CELL_H);
    nib_p0      = 4'h0;
    blank_lz_p0 = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (int'(ci) == d) begin
        nib_p0      = latched[4*(NUM_DIGITS-1-d) +: 4];
        blank_lz_p0 = LZ_BLANK && (d != NUM_DIGITS - 1) && lz_run[d];
      end
    end
  end

  // ---- stage 1: cell coordinates, nibble and syncs registered ----
  logic       vld_p1, hs_p1, vs_p1;
  logic       in_cell_p1, blank_lz_p1;
  logic [3:0] nib_p1;
  logic [5:0] cx_p1;
  logic [6:0] cy_p1;

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      hs_p1       <= 1'b1;
      vs_p1       <= 1'b1;
      in_cell_p1  <= 1'b0;
      blank_lz_p1 <= 1'b0;
      nib_p1      <= 4'h0;
      cx_p1       <= 6'd0;
      cy_p1       <= 7'd0;
    end else if (pix_tick) begin
      vld_p1      <= vld_p0;
      hs_p1       <= hs_p0;
      vs_p1       <= vs_p0;
      in_cell_p1  <= in_cell_p0;
      blank_lz_p1 <= blank_lz_p0;
      nib_p1      <= nib_p0;
      cx_p1       <= 6'(cxw);
      cy_p1       <= 7'(vy);
    end
  end

  // ---- stage 2: segment hit, colour select, pins ----
  logic        lit_p1;
  logic        vld_p2, hs_p2, vs_p2;
  logic [23:0] rgb_p2;

  assign lit_p1 = |(glyph(nib_p1) & seg_area(cx_p1, cy_p1));

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
      rgb_p2 <= 24'h0;
    end else if (pix_tick) begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      if (!vld_p1)                                   rgb_p2 <= 24'h0;
      else if (in_cell_p1 && lit_p1 && !blank_lz_p1) rgb_p2 <= FG_COLOR;
      else                                           rgb_p2 <= BG_COLOR;
    end
  end

  assign VGA_R       = rgb_p2[23:16];
  assign VGA_G       = rgb_p2[15:8];
  assign VGA_B       = rgb_p2[7:0];
  assign VGA_CLK     = div;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_BLANK_N = vld_p2;
  assign VGA_HS      = hs_p2;
  assign VGA_VS      = vs_p2;

endmodule
